mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares one line-granular DataMemory between the I-cache (port I) and the D-cache (port D).
//   Accepts one request at a time, converts byte address to line address, issues it to memory,
//   and routes the read line or write ack back to the owning cache. Sits between both caches and DataMemory.
// PARAMETERS
//   LINE_SIZE   16                  bytes per cache line; must be a power of two
//   LINE_BITS   `CLOG2(LINE_SIZE)   address shift; derived, not overridable
// PORTS
//   clk                   in   1              rising-edge clock
//   reset                 in   1              asynchronous, active-low (0 = reset)
//   i_req_valid           in   1              I-cache request pending; held until i_req_ready
//   i_req_ready           out  1              request accepted this cycle
//   i_req_write           in   1              1 = line write, 0 = line read
//   i_req_addr            in   32             byte address of line
//   i_req_din             in   LINE_SIZE*8    write line
//   i_rsp_valid           out  1              1-cycle pulse: read data valid / write done
//   i_rsp_dout            out  LINE_SIZE*8   read line; held until next response to I
//   d_req_* / d_rsp_*     --   --             identical set for the D-cache
//   mem_is_input_valid    out  1              to DataMemory is_input_valid
//   mem_addr              out  32             line address = req_addr >> LINE_BITS
//   mem_read / mem_write  out  1 / 1          to DataMemory; one-hot while mem_is_input_valid
//   mem_din               out  LINE_SIZE*8   write line
//   mem_is_output_valid   in   1              DataMemory read data valid
//   mem_dout              in   LINE_SIZE*8   DataMemory read line
//   mem_ready             in   1              DataMemory can accept a request
//   busy                  out  1              state != IDLE
// BEHAVIOUR
//   Reset (reset==0, async): state=IDLE, owner=D, rr_ptr=D. All outputs 0: *_req_ready, *_rsp_valid,
//     *_rsp_dout, mem_* and busy. An in-flight memory op is abandoned and produces no response.
//   FSM states: IDLE, ISSUE, WAIT_RD, WAIT_WR.
//   IDLE:    a pending request wins arbitration. Drive the winner's req_ready=1 combinationally.
//            Latch addr, write, din and owner. Go to ISSUE. With no request, stay in IDLE.
//   ISSUE:   drive mem_is_input_valid=1 from the latched request, only while mem_ready=1.
//            Then go to WAIT_RD (read) or WAIT_WR (write). While mem_ready=0, hold outputs at 0 and stay.
//   WAIT_RD: on mem_is_output_valid, register mem_dout into the owner's rsp_dout and pulse
//            the owner's rsp_valid on the next cycle. Go to IDLE.
//   WAIT_WR: spend at least 1 cycle here. On the first cycle with mem_ready=1 after that,
//            pulse the owner's rsp_valid. Go to IDLE.
//   Latency: accept in cycle 0 -> mem issue in cycle 1 at the earliest -> rsp_valid 1 cycle after mem_is_output_valid.
//   Only one transaction is outstanding. The next accept happens in the cycle after rsp_valid.
//   Arbitration when both requests are pending: see CONFIGURATION. With a single request, that port wins.
//   req_valid dropped before req_ready: no transaction is created. After accept, req_* changes are ignored (latched).
//   The non-owning port's rsp_valid is never asserted. The non-owning port's rsp_dout is unchanged.
//   mem_addr: the low LINE_BITS address bits are discarded. The upper LINE_BITS bits of mem_addr are zero.
// CONFIGURATION
//   MEM_ARB_RR_EN defined:     round-robin. rr_ptr flips to the other port after each accept;
//                              on conflict, rr_ptr's port wins.
//   MEM_ARB_RR_EN not defined: fixed priority, D always beats I. rr_ptr is absent.
// STRUCTURE
//   Constants.v: add `MEM_ARB_IDLE/ISSUE/WAIT_RD/WAIT_WR (2-bit) and `PORT_I=1'b0, `PORT_D=1'b1.
//   Reuse the existing CLOG2.v macro for LINE_BITS.
//   One sub-module: mem_arb_picker (combinational).
//     Inputs: i_valid, d_valid, rr_ptr. Outputs: grant_valid, grant_port.
//     Contains the MEM_ARB_RR_EN ifdef.
//   State, latch and response registers stay in mem_arbiter.
// TESTING
//   Read: D read 0x0000_0040, memory latency 5 -> mem_addr=0x4, mem_read=1;
//     d_rsp_valid pulses once with mem_dout; i_rsp_valid stays 0.
//   Conflict: I and D requests in the same cycle, fixed priority -> D accepted first, I accepted
//     in the cycle after d_rsp_valid. With MEM_ARB_RR_EN: D, then I, then D on a repeated conflict.
//   Write: D write 0x0000_0120, din=128'hA5.. -> mem_write=1, mem_addr=0x12, mem_din=din;
//     d_rsp_valid after mem_ready returns high.
//   Back-pressure: mem_ready=0 for 4 cycles in ISSUE -> mem_is_input_valid stays 0; issue happens when ready=1.
//   Reset: reset=0 during WAIT_RD -> busy=0 asynchronously, no rsp_valid.
//     After release, a new I read completes normally.
//   Withdrawal: i_req_valid high 1 cycle while the arbiter is busy, then low -> no I transaction issued.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared types and constants for the I/D-cache memory arbiter.
//   - arb_state_t : arbiter FSM state encoding (2 bits)
//   - PORT_I/PORT_D : port identifiers used for ownership and arbitration
//   - line_addr_of  : byte address -> line address conversion
//   Optional feature macro used by the arbiter files: MEM_ARB_RR_EN.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    WAIT_WR = 2'd3
  } arb_state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Discards the in-line byte offset; upper bits fill with zeros.
  function automatic logic [ADDR_W-1:0] line_addr_of(input logic [ADDR_W-1:0] byte_addr,
                                                     input int unsigned line_bits);
    return byte_addr >> line_bits;
  endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// -----------------------------------------------------------------------------
// mem_arb_picker
//   Combinational request picker for the memory arbiter.
//   Inputs : i_valid, d_valid  - pending requests from the I and D ports
//            rr_ptr            - port favoured on a conflict (round-robin build)
//   Outputs: grant_valid       - at least one request is pending
//            grant_port        - winning port (PORT_I / PORT_D)
//   Macro MEM_ARB_RR_EN: defined -> round-robin on conflict (rr_ptr wins);
//                        undefined -> fixed priority, D beats I, rr_ptr ignored.
// -----------------------------------------------------------------------------
module mem_arb_picker
  import mem_arbiter_pkg::*;
(
  input  logic i_valid,
  input  logic d_valid,
  input  logic rr_ptr,
  output logic grant_valid,
  output logic grant_port
);

  assign grant_valid = i_valid | d_valid;

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant_port = PORT_I;
    if (i_valid && d_valid) grant_port = rr_ptr;
    else if (d_valid)       grant_port = PORT_D;
  end
`else
  // Fixed priority has no use for the pointer.
  logic unused_rr_ptr;
  assign unused_rr_ptr = rr_ptr;

  always_comb begin
    grant_port = PORT_I;
    if (d_valid) grant_port = PORT_D;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one line-granular DataMemory between the I-cache and the D-cache.
//   One transaction outstanding at a time: accept -> issue -> wait -> respond.
//   Ports:
//     clk, reset (async, active-low)
//     i_req_valid/ready/write/addr/din, i_rsp_valid/dout : I-cache side
//     d_req_valid/ready/write/addr/din, d_rsp_valid/dout : D-cache side
//     mem_is_input_valid, mem_addr, mem_read, mem_write, mem_din : to memory
//     mem_is_output_valid, mem_dout, mem_ready                   : from memory
//     busy : FSM not idle
//   Macro MEM_ARB_RR_EN: defined -> round-robin arbitration with rr_ptr;
//                        undefined -> fixed priority (D over I).
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_req_valid,
  output logic                   i_req_ready,
  input  logic                   i_req_write,
  input  logic [31:0]            i_req_addr,
  input  logic [LINE_SIZE*8-1:0] i_req_din,
  output logic                   i_rsp_valid,
  output logic [LINE_SIZE*8-1:0] i_rsp_dout,
  input  logic                   d_req_valid,
  output logic                   d_req_ready,
  input  logic                   d_req_write,
  input  logic [31:0]            d_req_addr,
  input  logic [LINE_SIZE*8-1:0] d_req_din,
  output logic                   d_rsp_valid,
  output logic [LINE_SIZE*8-1:0] d_rsp_dout,
  output logic                   mem_is_input_valid,
  output logic [31:0]            mem_addr,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [LINE_SIZE*8-1:0] mem_din,
  input  logic                   mem_is_output_valid,
  input  logic [LINE_SIZE*8-1:0] mem_dout,
  input  logic                   mem_ready,
  output logic                   busy
);

  localparam int unsigned LINE_BITS = $clog2(LINE_SIZE);
  localparam int          LW        = LINE_SIZE * 8;

  arb_state_t  state;
  logic        owner;
  logic        write;
  logic [31:0] line_addr;
  logic [LW-1:0] din;

  logic        grant_valid;
  logic        grant_port;
  logic        rr_ptr;
  logic        accept;
  logic        issue;
  logic        sel_write;
  logic [31:0] sel_addr;
  logic [LW-1:0] sel_din;

  mem_arb_picker u_picker (
    .i_valid     (i_req_valid),
    .d_valid     (d_req_valid),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  // No accept while a response pulse is out: the next accept lands the
  // cycle after rsp_valid. Gated by reset so ready stays low in reset.
  assign accept = reset && (state == IDLE) && !i_rsp_valid && !d_rsp_valid && grant_valid;
  assign i_req_ready = accept && (grant_port == PORT_I);
  assign d_req_ready = accept && (grant_port == PORT_D);

  always_comb begin
    sel_write = i_req_write;
    sel_addr  = i_req_addr;
    sel_din   = i_req_din;
    if (grant_port == PORT_D) begin
      sel_write = d_req_write;
      sel_addr  = d_req_addr;
      sel_din   = d_req_din;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Pointer moves to the port that did not just win.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      rr_ptr <= PORT_D;
    else if (accept) rr_ptr <= ~grant_port;
  end
`else
  assign rr_ptr = PORT_D;
`endif

  // Memory command is only presented while memory can take it; otherwise
  // every memory-side output sits at zero.
  assign issue              = (state == ISSUE) && mem_ready;
  assign mem_is_input_valid = issue;
  assign mem_read           = issue && !write;
  assign mem_write          = issue && write;
  assign mem_addr           = issue ? line_addr : '0;
  assign mem_din            = (issue && write) ? din : '0;
  assign busy               = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= PORT_D;
      write       <= 1'b0;
      line_addr   <= '0;
      din         <= '0;
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      i_rsp_dout  <= '0;
      d_rsp_dout  <= '0;
    end else begin
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            owner     <= grant_port;
            write     <= sel_write;
            line_addr <= line_addr_of(sel_addr, LINE_BITS);
            din       <= sel_din;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) state <= write ? WAIT_WR : WAIT_RD;
        end
        WAIT_RD: begin
          if (mem_is_output_valid) begin
            if (owner == PORT_D) begin
              d_rsp_dout  <= mem_dout;
              d_rsp_valid <= 1'b1;
            end else begin
              i_rsp_dout  <= mem_dout;
              i_rsp_valid <= 1'b1;
            end
            state <= IDLE;
          end
        end
        WAIT_WR: begin
          // Entered at least one cycle after the issue, so the ack only
          // needs memory to be ready again.
          if (mem_ready) begin
            if (owner == PORT_D) d_rsp_valid <= 1'b1;
            else                 i_rsp_valid <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed self-checking bench for mem_arbiter (LINE_SIZE = 16).
//   Honours MEM_ARB_RR_EN for the expected conflict winners.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_req_valid, i_req_ready, i_req_write;
  logic [31:0]  i_req_addr;
  logic [127:0] i_req_din;
  logic         i_rsp_valid;
  logic [127:0] i_rsp_dout;
  logic         d_req_valid, d_req_ready, d_req_write;
  logic [31:0]  d_req_addr;
  logic [127:0] d_req_din;
  logic         d_rsp_valid;
  logic [127:0] d_rsp_dout;
  logic         mem_is_input_valid, mem_read, mem_write;
  logic [31:0]  mem_addr;
  logic [127:0] mem_din;
  logic         mem_is_output_valid, mem_ready;
  logic [127:0] mem_dout;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_i_dout, exp_d_dout;

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_SIZE(16)) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_req_valid         (i_req_valid),
    .i_req_ready         (i_req_ready),
    .i_req_write         (i_req_write),
    .i_req_addr          (i_req_addr),
    .i_req_din           (i_req_din),
    .i_rsp_valid         (i_rsp_valid),
    .i_rsp_dout          (i_rsp_dout),
    .d_req_valid         (d_req_valid),
    .d_req_ready         (d_req_ready),
    .d_req_write         (d_req_write),
    .d_req_addr          (d_req_addr),
    .d_req_din           (d_req_din),
    .d_rsp_valid         (d_rsp_valid),
    .d_rsp_dout          (d_rsp_dout),
    .mem_is_input_valid  (mem_is_input_valid),
    .mem_addr            (mem_addr),
    .mem_read            (mem_read),
    .mem_write           (mem_write),
    .mem_din             (mem_din),
    .mem_is_output_valid (mem_is_output_valid),
    .mem_dout            (mem_dout),
    .mem_ready           (mem_ready),
    .busy                (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge (drive point).
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One read transaction, starting at a drive point where the request(s)
  // are already presented. Ends at the drive point after the response pulse.
  task automatic read_txn(input string tag, input logic port, input logic [31:0] line,
                          input int latency, input logic [127:0] data, input logic drop);
    #1;
    check({tag, " i_req_ready"}, i_req_ready, port == PORT_I);
    check({tag, " d_req_ready"}, d_req_ready, port == PORT_D);
    tick();
    if (drop) begin
      if (port == PORT_D) begin d_req_valid = 1'b0; d_req_addr = 32'hDEAD_BEE0; end
      else                begin i_req_valid = 1'b0; i_req_addr = 32'hDEAD_BEE0; end
    end
    #1;
    check({tag, " mem_is_input_valid"}, mem_is_input_valid, 1'b1);
    check({tag, " mem_read"}, mem_read, 1'b1);
    check({tag, " mem_addr"}, mem_addr, line);
    tick();
    for (int k = 1; k < latency; k++) begin
      #1;
      check({tag, " early rsp"}, i_rsp_valid | d_rsp_valid, 1'b0);
      tick();
    end
    mem_is_output_valid = 1'b1;
    mem_dout            = data;
    tick();
    mem_is_output_valid = 1'b0;
    mem_dout            = '0;
    if (port == PORT_I) exp_i_dout = data;
    else                exp_d_dout = data;
    #1;
    check({tag, " i_rsp_valid"}, i_rsp_valid, port == PORT_I);
    check({tag, " d_rsp_valid"}, d_rsp_valid, port == PORT_D);
    check({tag, " i_rsp_dout"}, i_rsp_dout, exp_i_dout);
    check({tag, " d_rsp_dout"}, d_rsp_dout, exp_d_dout);
    check({tag, " no accept in rsp cycle"}, i_req_ready | d_req_ready, 1'b0);
    tick();
    #1;
    check({tag, " single pulse"}, i_rsp_valid | d_rsp_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic exp_win [4];
    logic [127:0] data;
`ifdef MEM_ARB_RR_EN
    exp_win[0] = PORT_D; exp_win[1] = PORT_I; exp_win[2] = PORT_D; exp_win[3] = PORT_I;
`else
    exp_win[0] = PORT_D; exp_win[1] = PORT_D; exp_win[2] = PORT_D; exp_win[3] = PORT_I;
`endif
    reset = 1'b0;
    i_req_valid = 0; i_req_write = 0; i_req_addr = '0; i_req_din = '0;
    d_req_valid = 1; d_req_write = 0; d_req_addr = 32'h40; d_req_din = '0;
    mem_is_output_valid = 0; mem_dout = '0; mem_ready = 1;
    exp_i_dout = '0; exp_d_dout = '0;

    // Reset state: outputs zero even with a request pending
    tick(); tick();
    check("rst d_req_ready", d_req_ready, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst mem_is_input_valid", mem_is_input_valid, 1'b0);
    check("rst rsp_valid", i_rsp_valid | d_rsp_valid, 1'b0);
    check("rst d_rsp_dout", d_rsp_dout, 128'h0);
    d_req_valid = 0;
    reset = 1'b1;
    tick();

    // D read at 0x40, memory latency 5
    d_req_valid = 1; d_req_write = 0; d_req_addr = 32'h0000_0040;
    read_txn("rd", PORT_D, 32'h4, 5, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1);

    // D write at 0x120 with mem_ready low for 2 cycles in WAIT_WR
    d_req_valid = 1; d_req_write = 1; d_req_addr = 32'h0000_0120; d_req_din = {16{8'hA5}};
    #1;
    check("wr d_req_ready", d_req_ready, 1'b1);
    tick();
    d_req_valid = 0; d_req_write = 0; d_req_din = '0; d_req_addr = '0;
    #1;
    check("wr mem_write", mem_write, 1'b1);
    check("wr mem_read", mem_read, 1'b0);
    check("wr mem_addr", mem_addr, 32'h12);
    check("wr mem_din", mem_din, {16{8'hA5}});
    tick();
    mem_ready = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      #1;
      check("wr held ack", d_rsp_valid, 1'b0);
      check("wr held busy", busy, 1'b1);
    end
    mem_ready = 1;
    tick();
    #1;
    check("wr d_rsp_valid", d_rsp_valid, 1'b1);
    check("wr i_rsp_valid", i_rsp_valid, 1'b0);
    check("wr d_rsp_dout kept", d_rsp_dout, exp_d_dout);
    tick();
    #1;
    check("wr single pulse", d_rsp_valid, 1'b0);

    // Back-pressure: I read at 0x1230 with mem_ready low for 4 ISSUE cycles
    mem_ready = 0;
    i_req_valid = 1; i_req_write = 0; i_req_addr = 32'h0000_1230;
    #1;
    check("bp i_req_ready", i_req_ready, 1'b1);
    tick();
    i_req_valid = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp no issue", mem_is_input_valid, 1'b0);
      check("bp mem_addr zero", mem_addr, 32'h0);
      tick();
    end
    mem_ready = 1;
    #1;
    check("bp issue", mem_is_input_valid, 1'b1);
    check("bp mem_addr", mem_addr, 32'h123);
    tick();
    data = 128'hB0B0_0000_1111_2222_3333_4444_5555_6666;
    mem_is_output_valid = 1; mem_dout = data;
    tick();
    mem_is_output_valid = 0; mem_dout = '0;
    exp_i_dout = data;
    #1;
    check("bp i_rsp_valid", i_rsp_valid, 1'b1);
    check("bp i_rsp_dout", i_rsp_dout, exp_i_dout);
    check("bp d_rsp_valid", d_rsp_valid, 1'b0);
    check("bp d_rsp_dout kept", d_rsp_dout, exp_d_dout);
    tick();

    // Conflicts: both ports keep requesting for three rounds, then D drops
    i_req_valid = 1; i_req_write = 0; i_req_addr = 32'h0000_0200;
    d_req_valid = 1; d_req_write = 0; d_req_addr = 32'h0000_0300;
    for (int r = 0; r < 4; r++) begin
      if (r == 3) d_req_valid = 0;
      read_txn($sformatf("arb%0d", r), exp_win[r],
               (exp_win[r] == PORT_D) ? 32'h30 : 32'h20, 1,
               {4{32'hC0DE_0000 + 32'(r)}}, 1'b0);
    end
    i_req_valid = 0;
    tick();

    // Withdrawal: I request pulses for one cycle while busy
    d_req_valid = 1; d_req_write = 0; d_req_addr = 32'h0000_0700;
    #1;
    check("wd d_req_ready", d_req_ready, 1'b1);
    tick();
    d_req_valid = 0;
    i_req_valid = 1; i_req_addr = 32'h0000_0990;
    #1;
    check("wd i_req_ready", i_req_ready, 1'b0);
    check("wd mem_addr", mem_addr, 32'h70);
    tick();
    i_req_valid = 0;
    data = 128'h7777_0000_0000_0000_0000_0000_0000_7777;
    mem_is_output_valid = 1; mem_dout = data;
    tick();
    mem_is_output_valid = 0; mem_dout = '0;
    exp_d_dout = data;
    #1;
    check("wd d_rsp_valid", d_rsp_valid, 1'b1);
    check("wd d_rsp_dout", d_rsp_dout, exp_d_dout);
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      check("wd no I issue", mem_is_input_valid, 1'b0);
      check("wd idle", busy, 1'b0);
    end
    tick();

    // Reset during WAIT_RD abandons the read
    d_req_valid = 1; d_req_write = 0; d_req_addr = 32'h0000_0080;
    #1;
    check("rr d_req_ready", d_req_ready, 1'b1);
    tick();
    d_req_valid = 0;
    tick();
    tick();
    #1;
    check("rr pre busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("rr async busy", busy, 1'b0);
    check("rr d_rsp_dout", d_rsp_dout, 128'h0);
    mem_is_output_valid = 1; mem_dout = {4{32'hFFFF_0000}};
    tick();
    #1;
    check("rr no rsp", i_rsp_valid | d_rsp_valid, 1'b0);
    reset = 1'b1;
    mem_is_output_valid = 0; mem_dout = '0;
    tick();
    #1;
    check("rr after release rsp", i_rsp_valid | d_rsp_valid, 1'b0);
    check("rr after release busy", busy, 1'b0);
    exp_i_dout = '0; exp_d_dout = '0;
    tick();
    i_req_valid = 1; i_req_write = 0; i_req_addr = 32'h0000_0550;
    read_txn("post_rst", PORT_I, 32'h55, 2, 128'hABCD_EF01_2345_6789_0000_1111_2222_3333, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
